layer5_maxpool_fetch: RTL and testbench

Downstream consumer of the layer-4 result memory. On a start pulse it walks the stored WIDTH×WIDTH layer-4 feature map in 2×2 non-overlapping windows and drives the memory's read port (row/col address plus read strobe). It computes a per-channel signed maximum over each window and presents one pooled word per window to the layer-5 stage through a valid/ready handshake, tagged with its output coordinates.

---
 rtl/layer5_maxpool_fetch.sv | 153 +++++++++++++++
 tb/tb_layer5_maxpool_fetch.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/layer5_maxpool_fetch.sv
// layer5_maxpool_fetch
// Walks the layer-4 result map in 2x2 non-overlapping windows, reads the four
// words of each window through the memory read port, keeps a per-channel
// signed maximum and hands one pooled word per window to layer 5 over a
// valid/ready handshake, tagged with its output-map coordinates.

module layer5_maxpool_fetch #(
    parameter int WIDTH = 8,
    parameter int CH    = 8,
    parameter int DW    = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic [15:0]        read_row_addr,
    output logic [15:0]        read_col_addr,
    output logic               layer4_result_read_signal,
    input  logic [CH*DW-1:0]   layer4_result_output,
    output logic               pool_valid,
    input  logic               pool_ready,
    output logic [CH*DW-1:0]   pool_data,
    output logic [15:0]        pool_row,
    output logic [15:0]        pool_col
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        OUT   = 2'd2,
        FIN   = 2'd3
    } state_t;

    // Index of the last window along either axis of the output map.
    localparam logic [15:0] LAST_WIN = 16'(WIDTH / 2 - 1);

    state_t             state, state_next;
    logic [15:0]        wr, wr_next;
    logic [15:0]        wc, wc_next;
    logic [1:0]         k, k_next;
    logic [CH*DW-1:0]   acc, acc_next;

    // State, window counters, element counter and accumulator registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            wr    <= '0;
            wc    <= '0;
            k     <= '0;
            acc   <= '0;
        end else begin
            state <= state_next;
            wr    <= wr_next;
            wc    <= wc_next;
            k     <= k_next;
            acc   <= acc_next;
        end
    end

    // Next-state logic: window sequencing in raster order over the output map.
    always_comb begin
        state_next = state;
        wr_next    = wr;
        wc_next    = wc;
        k_next     = k;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = FETCH;
                    wr_next    = '0;
                    wc_next    = '0;
                    k_next     = '0;
                end
            end
            FETCH: begin
                k_next = k + 2'd1;
                if (k == 2'd3) begin
                    state_next = OUT;
                end
            end
            OUT: begin
                if (pool_ready) begin
                    if (wc < LAST_WIN) begin
                        wc_next    = wc + 16'd1;
                        state_next = FETCH;
                    end else if (wr < LAST_WIN) begin
                        wc_next    = '0;
                        wr_next    = wr + 16'd1;
                        state_next = FETCH;
                    end else begin
                        state_next = FIN;
                    end
                end
            end
            FIN: begin
                state_next = IDLE;
                wr_next    = '0;
                wc_next    = '0;
                k_next     = '0;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Accumulator: first element of a window loads, later ones keep the signed max per channel.
    always_comb begin
        acc_next = acc;
        if (state == FETCH) begin
            for (int c = 0; c < CH; c++) begin
                if (k == 2'd0) begin
                    acc_next[c*DW +: DW] = layer4_result_output[c*DW +: DW];
                end else if ($signed(layer4_result_output[c*DW +: DW]) > $signed(acc[c*DW +: DW])) begin
                    acc_next[c*DW +: DW] = layer4_result_output[c*DW +: DW];
                end
            end
        end
    end

    // Output decode: read port only active in FETCH, pooled word only presented in OUT.
    always_comb begin
        busy                      = (state != IDLE);
        done                      = 1'b0;
        read_row_addr             = '0;
        read_col_addr             = '0;
        layer4_result_read_signal = 1'b0;
        pool_valid                = 1'b0;
        pool_data                 = '0;
        pool_row                  = '0;
        pool_col                  = '0;
        case (state)
            FETCH: begin
                layer4_result_read_signal = 1'b1;
                read_row_addr             = {wr[14:0], k[1]};
                read_col_addr             = {wc[14:0], k[0]};
            end
            OUT: begin
                pool_valid = 1'b1;
                pool_data  = acc;
                pool_row   = wr;
                pool_col   = wc;
            end
            FIN: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_layer5_maxpool_fetch.sv
// tb_layer5_maxpool_fetch
// Randomized and directed passes over a modelled layer-4 memory, compared
// against a window-level reference model of 2x2 signed max pooling.

module tb_layer5_maxpool_fetch;

    localparam int W    = 8;
    localparam int CH   = 8;
    localparam int DW   = 16;
    localparam int HALF = W / 2;
    localparam int NWIN = HALF * HALF;

    logic               clk;
    logic               rst;
    logic               start;
    logic               busy;
    logic               done;
    logic [15:0]        read_row_addr;
    logic [15:0]        read_col_addr;
    logic               layer4_result_read_signal;
    logic [CH*DW-1:0]   layer4_result_output;
    logic               pool_valid;
    logic               pool_ready;
    logic [CH*DW-1:0]   pool_data;
    logic [15:0]        pool_row;
    logic [15:0]        pool_col;

    logic [CH*DW-1:0]   mem [W*W];
    logic [CH*DW-1:0]   got [NWIN];

    int checks = 0;
    int errors = 0;

    layer5_maxpool_fetch #(.WIDTH(W), .CH(CH), .DW(DW)) dut (
        .clk                       (clk),
        .rst                       (rst),
        .start                     (start),
        .busy                      (busy),
        .done                      (done),
        .read_row_addr             (read_row_addr),
        .read_col_addr             (read_col_addr),
        .layer4_result_read_signal (layer4_result_read_signal),
        .layer4_result_output      (layer4_result_output),
        .pool_valid                (pool_valid),
        .pool_ready                (pool_ready),
        .pool_data                 (pool_data),
        .pool_row                  (pool_row),
        .pool_col                  (pool_col)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory read data is combinational from the addresses.
    always_comb begin
        layer4_result_output = '0;
        if (read_row_addr < 16'(W) && read_col_addr < 16'(W)) begin
            layer4_result_output = mem[int'(read_row_addr) * W + int'(read_col_addr)];
        end
    end

    task automatic checkOutput(input string tag, input logic [CH*DW-1:0] actual,
                               input logic [CH*DW-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
        end
    endtask

    // Reference: per-channel signed max over the four words of window (wr, wc).
    function automatic logic [CH*DW-1:0] modelWindow(input int wr, input int wc);
        logic [CH*DW-1:0]   res;
        logic signed [DW-1:0] best;
        logic signed [DW-1:0] v;
        logic [CH*DW-1:0]   word;
        res = '0;
        for (int ch = 0; ch < CH; ch++) begin
            word = mem[(2*wr) * W + 2*wc];
            best = $signed(word[ch*DW +: DW]);
            for (int e = 1; e < 4; e++) begin
                word = mem[(2*wr + e/2) * W + 2*wc + e%2];
                v = $signed(word[ch*DW +: DW]);
                if (v > best) best = v;
            end
            res[ch*DW +: DW] = best;
        end
        return res;
    endfunction

    task automatic fillRandom();
        for (int i = 0; i < W*W; i++) begin
            for (int ch = 0; ch < CH; ch++) begin
                mem[i][ch*DW +: DW] = 16'($urandom);
            end
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_done"}, done, 0);
        checkOutput({tag, "_strobe"}, layer4_result_read_signal, 0);
        checkOutput({tag, "_raddr"}, {read_row_addr, read_col_addr}, 0);
        checkOutput({tag, "_valid"}, pool_valid, 0);
        checkOutput({tag, "_pdata"}, pool_data, 0);
        checkOutput({tag, "_prc"}, {pool_row, pool_col}, 0);
    endtask

    // One full pass: optional stall of stall_n cycles at window stall_win, optional start pokes while busy.
    task automatic applyStimulus(input int stall_win, input int stall_n, input bit poke);
        int cyc;
        int win_idx;
        int fetch_n;
        int stall_left;
        int done_cnt;
        int done_cyc;
        int ew, ek;
        logic [CH*DW-1:0] exp_word;
        win_idx    = 0;
        fetch_n    = 0;
        stall_left = stall_n;
        done_cnt   = 0;
        done_cyc   = -1;
        pool_ready = 1'b1;
        start      = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc   = 1;
        forever begin
            if (layer4_result_read_signal) begin
                ew = fetch_n / 4;
                ek = fetch_n % 4;
                checkOutput("fetch_addr", {read_row_addr, read_col_addr},
                            {16'(2*(ew/HALF) + ek/2), 16'(2*(ew%HALF) + ek%2)});
                fetch_n++;
            end else begin
                checkOutput("idle_addr", {read_row_addr, read_col_addr}, 0);
            end
            if (pool_valid) begin
                exp_word = (win_idx < NWIN) ? modelWindow(win_idx / HALF, win_idx % HALF) : '0;
                checkOutput("pool_data", pool_data, exp_word);
                checkOutput("pool_rc", {pool_row, pool_col},
                            {16'(win_idx / HALF), 16'(win_idx % HALF)});
                if (win_idx < NWIN) got[win_idx] = pool_data;
                if (win_idx == stall_win && stall_left > 0) begin
                    pool_ready = 1'b0;
                    stall_left--;
                    checkOutput("stall_strobe", layer4_result_read_signal, 0);
                end else begin
                    pool_ready = 1'b1;
                    win_idx++;
                end
            end else begin
                pool_ready = 1'b1;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            start = poke && (cyc == 2 || cyc == 5);
            if (!busy) break;
            if (cyc >= 400) begin
                checkOutput("timeout", 1, 0);
                break;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start      = 1'b0;
        pool_ready = 1'b1;
        checkOutput("done_count", done_cnt, 1);
        checkOutput("done_cycle", done_cyc, NWIN*5 + 1 + stall_n);
        checkOutput("busy_fall", cyc, done_cyc + 1);
        checkOutput("windows", win_idx, NWIN);
        checkOutput("fetches", fetch_n, 4*NWIN);
    endtask

    initial begin
        logic [CH*DW-1:0] w;
        rst        = 1'b1;
        start      = 1'b0;
        pool_ready = 1'b1;
        for (int i = 0; i < W*W; i++) mem[i] = '0;
        #1;
        checkAllZero("reset");
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        checkAllZero("post_reset");

        // Ramp: every channel of word (r,c) holds r*W+c.
        $display("[TB] ramp pass");
        for (int r = 0; r < W; r++) begin
            for (int c = 0; c < W; c++) begin
                for (int ch = 0; ch < CH; ch++) mem[r*W+c][ch*DW +: DW] = 16'(r*W + c);
            end
        end
        applyStimulus(-1, 0, 1'b0);
        w = got[NWIN-1];
        checkOutput("ramp_last", w[DW-1:0], 63);
        w = got[0];
        checkOutput("ramp_first", w[7*DW +: DW], 9);

        // Signed compare in window (1,2).
        $display("[TB] signed compare pass");
        fillRandom();
        mem[2*W+4][DW-1:0] = 16'hFFFB; mem[2*W+4][7*DW +: DW] = 16'h7FFF;
        mem[2*W+5][DW-1:0] = 16'hFFFF; mem[2*W+5][7*DW +: DW] = 16'h0000;
        mem[3*W+4][DW-1:0] = 16'h8000; mem[3*W+4][7*DW +: DW] = 16'hFFFF;
        mem[3*W+5][DW-1:0] = 16'hFFFE; mem[3*W+5][7*DW +: DW] = 16'h0005;
        applyStimulus(-1, 0, 1'b0);
        w = got[1*HALF + 2];
        checkOutput("signed_ch0", w[DW-1:0], 16'hFFFF);
        checkOutput("signed_ch7", w[7*DW +: DW], 16'h7FFF);

        // Back-pressure at window (0,1).
        $display("[TB] back-pressure pass");
        fillRandom();
        applyStimulus(1, 3, 1'b0);

        // Start pulses while busy.
        $display("[TB] start-while-busy pass");
        fillRandom();
        applyStimulus(-1, 0, 1'b1);
        repeat (3) begin
            @(posedge clk); #1;
            checkOutput("no_restart", busy, 0);
        end

        // Reset asserted in cycle 12 of a pass.
        $display("[TB] reset mid-operation");
        fillRandom();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (11) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #1;
        checkAllZero("mid_reset");
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            checkOutput("no_done_after_reset", {busy, done}, 0);
        end
        applyStimulus(-1, 0, 1'b0);

        // A few more random passes with random stalls.
        for (int p = 0; p < 3; p++) begin
            $display("[TB] random pass %0d", p);
            fillRandom();
            applyStimulus(int'($urandom_range(NWIN-1)), int'($urandom_range(4)), 1'(p % 2));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
